// File: rtl/drone_fsm_pkg.sv
// drone_fsm_pkg
//
// Purpose: shared types and constants for the flight-sequencing controller.
//   - flightState_e : the four flight phases of the controller
//   - DEF_*_CYCLES  : default confirmation / takeoff / landing durations
//   - counterWidth  : width needed to hold the largest of the three counts
//
// Ports: none (package).

package drone_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKEOFF = 2'd1,
        FLY     = 2'd2,
        LANDING = 2'd3
    } flightState_e;

    localparam int DEF_CONFIRM_CYCLES = 2;
    localparam int DEF_TAKEOFF_CYCLES = 4;
    localparam int DEF_LAND_CYCLES    = 4;

    // Bits needed to hold any value 0..max(a, b, c) without wrapping.
    function automatic int counterWidth(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/drone_fsm_timer.sv
// drone_fsm_timer
//
// Purpose: loadable down-counter shared by the TAKEOFF and LANDING phases.
//   A load of N makes expired_o rise during the N-th cycle after the load,
//   so the owning state lasts exactly N cycles when it leaves on expired_o.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   load_i       in   load load_val_i into the counter on this edge
//   load_val_i   in   phase length in cycles (>= 1)
//   expired_o    out  high during the last cycle of the loaded phase

module drone_fsm_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over counting; once at zero the counter rests there.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A value of one means the coming edge ends the phase.
    assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/drone_fsm.sv
// drone_fsm
//
// Purpose: flight-sequencing controller. Issues a timed takeoff once the
//   gyro self-test and receiver link have been healthy for CONFIRM_CYCLES
//   consecutive edges, and a timed landing whenever either fails after
//   takeoff has begun.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   gyrocheck      in   gyro self-test pass (1 = healthy)
//   reciverenable  in   receiver link valid (1 = healthy)
//   takeoff        out  climb command, high exactly while in TAKEOFF
//   landing        out  descend command, high exactly while in LANDING

module drone_fsm
    import drone_fsm_pkg::*;
#(
    parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
    parameter int TAKEOFF_CYCLES = DEF_TAKEOFF_CYCLES,
    parameter int LAND_CYCLES    = DEF_LAND_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic gyrocheck,
    input  logic reciverenable,
    output logic takeoff,
    output logic landing
);

    localparam int CNT_W = counterWidth(CONFIRM_CYCLES, TAKEOFF_CYCLES, LAND_CYCLES);

    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAKEOFF_LOAD = CNT_W'(TAKEOFF_CYCLES);
    localparam logic [CNT_W-1:0] LAND_LOAD    = CNT_W'(LAND_CYCLES);

    flightState_e     state_q;
    flightState_e     state_d;
    logic [CNT_W-1:0] confirm_q;
    logic [CNT_W-1:0] confirm_d;
    logic             takeoff_q;
    logic             landing_q;

    logic             healthy;
    logic             timerLoad;
    logic [CNT_W-1:0] timerLoadVal;
    logic             timerExpired;

    assign healthy = gyrocheck & reciverenable;

    drone_fsm_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (timerLoad),
        .load_val_i(timerLoadVal),
        .expired_o (timerExpired)
    );

    // Next-state and confirm-counter logic. The confirm counter only counts
    // in IDLE and is zero in every other state, so each return to IDLE needs
    // a fresh full confirmation. Transition happens on the edge that would
    // complete the confirmation, hence the compare against CONFIRM_CYCLES-1.
    always_comb begin
        state_d      = state_q;
        confirm_d    = '0;
        timerLoad    = 1'b0;
        timerLoadVal = '0;

        case (state_q)
            IDLE: begin
                if (healthy) begin
                    if (confirm_q >= CONFIRM_LAST) begin
                        state_d      = TAKEOFF;
                        timerLoad    = 1'b1;
                        timerLoadVal = TAKEOFF_LOAD;
                    end else begin
                        confirm_d = confirm_q + 1'b1;
                    end
                end
            end

            // Abort is checked first so a dropout on the expiry edge lands.
            TAKEOFF: begin
                if (!healthy) begin
                    state_d      = LANDING;
                    timerLoad    = 1'b1;
                    timerLoadVal = LAND_LOAD;
                end else if (timerExpired) begin
                    state_d = FLY;
                end
            end

            FLY: begin
                if (!healthy) begin
                    state_d      = LANDING;
                    timerLoad    = 1'b1;
                    timerLoadVal = LAND_LOAD;
                end
            end

            LANDING: begin
                if (timerExpired) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state, so the
    // commands change on the same edge as the state and never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            confirm_q <= '0;
            takeoff_q <= 1'b0;
            landing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            confirm_q <= confirm_d;
            takeoff_q <= (state_d == TAKEOFF);
            landing_q <= (state_d == LANDING);
        end
    end

    assign takeoff = takeoff_q;
    assign landing = landing_q;

endmodule

// File: tb/tb_drone_fsm.sv
// tb_drone_fsm
//
// Purpose: self-checking bench for drone_fsm with default parameters.
//   Each driven cycle advances a small behavioural flight model and pushes
//   the expected {takeoff, landing} pair to a scoreboard queue; after the
//   clock edge the pair is popped and compared with the DUT outputs.
//
// Ports: none (top-level bench).

module tb_drone_fsm;

    localparam int CONF = 2;
    localparam int TO   = 4;
    localparam int LAND = 4;

    typedef struct {
        string      tag;
        logic [1:0] expected;
    } sbItem_t;

    logic clk;
    logic reset;
    logic gyrocheck;
    logic reciverenable;
    logic takeoff;
    logic landing;

    sbItem_t scoreboard[$];

    int checkCount;
    int errorCount;
    int cycleNum;

    // Flight model: 0 idle, 1 takeoff, 2 fly, 3 landing
    int mState;
    int mRun;
    int mLeft;

    drone_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .gyrocheck    (gyrocheck),
        .reciverenable(reciverenable),
        .takeoff      (takeoff),
        .landing      (landing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got {takeoff,landing}=%b, expected %b", tag, actual, expected);
        end
    endtask

    function automatic void modelReset();
        mState = 0;
        mRun   = 0;
        mLeft  = 0;
    endfunction

    // One clock edge of the reference model, given the healthy sample.
    function automatic void modelEdge(input bit h);
        case (mState)
            0: begin
                if (h) begin
                    mRun++;
                    if (mRun >= CONF) begin
                        mState = 1;
                        mLeft  = TO;
                        mRun   = 0;
                    end
                end else begin
                    mRun = 0;
                end
            end
            1: begin
                if (!h) begin
                    mState = 3;
                    mLeft  = LAND;
                end else begin
                    mLeft--;
                    if (mLeft == 0) mState = 2;
                end
            end
            2: begin
                if (!h) begin
                    mState = 3;
                    mLeft  = LAND;
                end
            end
            default: begin
                mLeft--;
                if (mLeft == 0) begin
                    mState = 0;
                    mRun   = 0;
                end
            end
        endcase
    endfunction

    // Drive one cycle of inputs, predict, wait for the edge, then compare.
    task automatic applyStimulus(input string scen, input logic g, input logic r);
        sbItem_t item;
        sbItem_t got;
        gyrocheck     = g;
        reciverenable = r;
        modelEdge(g & r);
        item.tag      = $sformatf("%s_c%0d", scen, cycleNum);
        item.expected = {(mState == 1), (mState == 3)};
        scoreboard.push_back(item);
        @(posedge clk);
        #1;
        cycleNum++;
        got = scoreboard.pop_front();
        checkOutput(got.tag, {takeoff, landing}, got.expected);
        if (takeoff && landing) begin
            checkOutput({got.tag, "_exclusive"}, {takeoff, landing}, 2'b10);
        end
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        cycleNum      = 0;
        reset         = 1'b0;
        gyrocheck     = 1'b1;
        reciverenable = 1'b1;
        modelReset();

        // Held in reset with healthy inputs: outputs must stay low.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rst_hold_%0d", i), {takeoff, landing}, 2'b00);
        end
        reset = 1'b1;

        // Only one input healthy at a time never confirms.
        for (int i = 0; i < 10; i++) applyStimulus("gyro_only", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus("rx_only", 1'b0, 1'b1);

        // Normal takeoff then FLY.
        for (int i = 0; i < CONF + TO + 3; i++) applyStimulus("normal", 1'b1, 1'b1);

        // FLY loss with immediate recovery still lands, then fresh confirm.
        applyStimulus("fly_loss", 1'b1, 1'b0);
        for (int i = 0; i < LAND + CONF + 1; i++) applyStimulus("fly_loss", 1'b1, 1'b1);

        // Land from the takeoff just started, inputs ignored while landing.
        applyStimulus("abort_prep", 1'b0, 1'b1);
        for (int i = 0; i < LAND; i++) applyStimulus("abort_land", 1'b1, 1'b0);
        applyStimulus("abort_idle", 1'b0, 1'b0);

        // Abort on the third edge of a fresh sequence.
        applyStimulus("abort", 1'b1, 1'b1);
        applyStimulus("abort", 1'b1, 1'b1);
        applyStimulus("abort", 1'b0, 1'b1);
        for (int i = 0; i < LAND + 1; i++) applyStimulus("abort_after", 1'b0, 1'b0);

        // Confirmation glitch 1,0,1,1.
        applyStimulus("glitch", 1'b1, 1'b1);
        applyStimulus("glitch", 1'b0, 1'b1);
        applyStimulus("glitch", 1'b1, 1'b1);
        applyStimulus("glitch", 1'b1, 1'b1);
        applyStimulus("glitch", 1'b1, 1'b1);

        // Asynchronous reset in the middle of TAKEOFF.
        reset = 1'b0;
        #1;
        checkOutput("rst_async_mid_takeoff", {takeoff, landing}, 2'b00);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("rst_async_no_landing", {takeoff, landing}, 2'b00);
        reset = 1'b1;

        // Random stretch biased toward healthy inputs.
        for (int i = 0; i < 80; i++) begin
            applyStimulus("rand", ($urandom_range(0, 11) != 0), ($urandom_range(0, 11) != 0));
        end

        if (scoreboard.size() != 0) begin
            checkOutput("scoreboard_drain", 2'(scoreboard.size()), 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/drone_fsm.md
# drone_fsm

Flight-sequencing controller for the drone's top-level control path. It monitors the gyro self-test status and the radio-receiver link. It issues a timed takeoff command once both are continuously healthy, and a timed landing command whenever either fails after takeoff has begun. It sits between the sensor/receiver status logic and the motor-command logic.

## Interface
- CONFIRM_CYCLES, default 2: consecutive cycles both inputs must be high in IDLE before takeoff; legal range ≥1.
- TAKEOFF_CYCLES, default 4: cycles `takeoff` stays asserted in TAKEOFF; legal range ≥1.
- LAND_CYCLES, default 4: cycles `landing` stays asserted in LANDING; legal range ≥1.
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- gyrocheck  input  1  gyro self-test pass (1 = healthy); synchronous to clk.
- reciverenable  input  1  receiver link valid (1 = healthy); synchronous to clk.
- takeoff  output  1  climb command; high exactly while in TAKEOFF.
- landing  output  1  descend command; high exactly while in LANDING.

## Operation
- States: IDLE, TAKEOFF, FLY, LANDING. Moore machine; outputs decode from the state register only. Encoding is free.
- `healthy` = gyrocheck & reciverenable.
- IDLE: both outputs 0.
  - Confirm counter increments on each edge where healthy=1 and clears on any edge where healthy=0.
  - When healthy=1 on the edge that would complete CONFIRM_CYCLES consecutive healthy samples, go to TAKEOFF and load the timer with TAKEOFF_CYCLES.
- TAKEOFF: takeoff=1.
  - If healthy=0 on an edge, go to LANDING. Abort has priority over timer expiry.
  - Otherwise, on the edge where the timer expires, go to FLY.
- FLY: both outputs 0.
  - Stay while healthy=1.
  - Go to LANDING on the first edge with healthy=0.
- LANDING: landing=1.
  - Inputs are ignored.
  - After LAND_CYCLES edges, go to IDLE with the confirm counter cleared, so a fresh full confirmation is needed.
- Invariant: takeoff and landing are never both 1.
- Counter and timer width: $clog2(max(CONFIRM_CYCLES, TAKEOFF_CYCLES, LAND_CYCLES)+1). No wrap: the confirm counter saturates at CONFIRM_CYCLES.

## Timing
- Reset asserted (reset=0):
  - Immediately, asynchronously: state=IDLE, counters=0, takeoff=0, landing=0.
  - Applies mid-takeoff or mid-landing too; no landing sequence is generated.
- Reset release:
  - The first rising edge with reset=1 is the first sampling edge.
  - Inputs present on that edge count toward confirmation.
- Takeoff latency: healthy high on edges k … k+CONFIRM_CYCLES−1 gives takeoff=1 after edge k+CONFIRM_CYCLES−1.
- Takeoff duration: takeoff stays high for exactly TAKEOFF_CYCLES cycles if no abort.
- Abort latency: healthy low at edge j in TAKEOFF or FLY gives landing=1 after edge j, and takeoff drops on the same edge.
- Landing duration: landing stays high for exactly LAND_CYCLES cycles, then both outputs are 0.
- A single-cycle healthy glitch in IDLE restarts confirmation.
- A single-cycle dropout in TAKEOFF or FLY still lands.

## Structure
- Package drone_fsm_pkg:
  - State enum type.
  - Default constants for the three cycle counts.
  - Counter-width helper function.
- Sub-module drone_fsm_timer: loadable down-counter.
  - Ports: clk, reset, load, load value, expired flag.
  - Shared by TAKEOFF and LANDING.
- Top drone_fsm holds the state register, the confirm counter and the output decode.

## Test plan
All scenarios use default parameters.
- Reset: hold reset=0 with healthy=1 for 5 cycles → takeoff=0, landing=0 throughout; asserting reset mid-TAKEOFF clears takeoff asynchronously (before the next edge).
- Single-input health: gyrocheck=1/reciverenable=0 for 10 cycles, then 0/1 for 10 cycles → takeoff and landing stay 0.
- Normal takeoff: both inputs 1 from edge 1 → takeoff=1 after edge 2, high 4 cycles, then FLY (both 0) while inputs stay 1.
- Abort during takeoff: both inputs 1 for 2 edges, then gyrocheck=0 at the 3rd edge → takeoff drops and landing=1 after that edge, held 4 cycles, then IDLE.
- FLY loss: in FLY, drop reciverenable for one cycle → landing=1 for 4 cycles even though the input recovers; then IDLE and 2 fresh healthy edges are needed for takeoff.
- Confirmation glitch: pattern healthy 1,0,1,1 → takeoff only after the final 1 (after the 4th edge).
